adder_bist: RTL and testbench
=============================

# adder_bist

Self-test engine for the WIDTH-bit ripple adder (`top`: A, B, Cin → Sum, Cout).
- Drives an exhaustive operand sweep into the adder, samples Sum/Cout after a settle delay, and compares them against an internal reference sum.
- Reports pass/fail, a saturating error count and the first failing vector.
- Synthesisable on-chip checker: the response side of the adder's stimulus sweep.

## Interface
- WIDTH, 4, adder operand width.
- SETTLE, 1, cycles between driving a vector and sampling the response (0 allowed).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level; sampled only in IDLE; begins a sweep.
- A  out  WIDTH  operand A to adder.
- B  out  WIDTH  operand B to adder.
- Cin  out  1  carry-in to adder.
- Sum  in  WIDTH  adder sum.
- Cout  in  1  adder carry-out.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  valid from done; held until the next accepted start.
- err_count  out  16  mismatching vectors, saturating at 16'hFFFF.
- fail_vec  out  2*WIDTH+1  {A,B,Cin} of the first mismatch; 0 if none.

## Operation
- N = 2^(2*WIDTH) vectors; index v counts 0..N-1. {A,B} = v, so B changes fastest. Cin = 0 (see Configuration).
- FSM states:
  - IDLE: A=B=Cin=0, busy=0. On start=1: v=0; clear err_count, fail_vec, pass and the first-fail flag; drive vector 0; busy=1. Next state is SETTLE, or CHECK if SETTLE=0.
  - SETTLE: settle counter loaded with SETTLE−1; decrements each cycle; goes to CHECK when it reaches 0.
  - CHECK: one cycle. Expected = A+B+Cin, computed at WIDTH+1 bits, compared with {Cout,Sum}.
    - On mismatch: err_count increments, saturating.
    - If the first-fail flag is clear: capture {A,B,Cin} into fail_vec and set the flag.
    - If v = N−1, go to DONE. Otherwise increment v, drive the new vector, and go to SETTLE (or CHECK if SETTLE=0).
  - DONE: one cycle. done=1, busy=0. pass = (err_count==0), including the final CHECK result. Then IDLE.
- A/B/Cin are registered outputs and stay stable for the whole SETTLE+CHECK window of each vector.
- start is ignored outside IDLE, including during DONE. If start is held high, a new sweep is accepted in the IDLE cycle after DONE.

## Timing
- Reset values: A=0, B=0, Cin=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, state=IDLE, v=0.
- Reset mid-sweep forces the reset values immediately (asynchronously). The sweep is abandoned; the next start restarts from vector 0.
- Each vector occupies SETTLE+1 cycles.
- If start is sampled at edge k, vector 0 appears after edge k.
- done is high in the cycle after edge k + N*(SETTLE+1).
- Default parameters, macro off: busy for 512 cycles, done pulse in cycle 513.
- The response is sampled at the clock edge ending the CHECK cycle. The adder path must settle within SETTLE+1 cycles.

## Configuration
- ADDER_BIST_CIN_EN defined:
  - N = 2^(2*WIDTH+1) and {A,B,Cin} = v, so Cin toggles fastest.
  - Defaults give 512 vectors and 1024 busy cycles.
- Undefined: Cin is tied to 0 and N = 2^(2*WIDTH). fail_vec[0] is always 0.

## Test plan
- Reset: assert rst mid-clock with start=1 → all outputs 0 with no clock edge needed; no sweep until rst deasserts and start is sampled in IDLE.
- Correct adder model, defaults, macro off, 1-cycle start pulse:
  - Required: busy high 512 cycles; A/B step 0x00..0xFF with B fastest; Cin=0.
  - At the end: single done pulse, pass=1, err_count=0, fail_vec=0.
- Sum[0] stuck-at-0 → done with pass=0, err_count=128, fail_vec=9'h002 (A=0, B=1).
- Cout stuck-at-0 → err_count=120, fail_vec=9'h03E (A=1, B=15).
- Control robustness:
  - start held high → back-to-back sweeps, each clearing err_count/pass on acceptance.
  - start pulses mid-sweep → ignored.
  - rst at vector 100 → outputs 0 immediately; a later start restarts at A=0, B=0.
- ADDER_BIST_CIN_EN defined, correct adder → 512 vectors; Cin alternates every 2 cycles; done after 1024 cycles; pass=1. With Cin ignored by the adder model → err_count=256, fail_vec=9'h001.

Source files
------------

// File: rtl/adder_bist.sv
// adder_bist: on-chip self-test engine for a WIDTH-bit ripple adder.
// Sweeps every operand combination into the adder and waits SETTLE cycles
// after each one. It then compares {Cout,Sum} with a reference sum and reports
// pass/fail, a saturating error count and the first failing vector.
//
// Build option: define ADDER_BIST_CIN_EN to include carry-in in the sweep
// ({A,B,Cin} = vector index). Without it, Cin is tied to 0 and only {A,B} is
// swept.

module adder_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic               Cin,
    input  logic [WIDTH-1:0]   Sum,
    input  logic               Cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [2*WIDTH:0]   fail_vec
);

`ifdef ADDER_BIST_CIN_EN
    localparam int vec_w = 2 * WIDTH + 1;
`else
    localparam int vec_w = 2 * WIDTH;
`endif

    localparam logic [vec_w-1:0] vec_last = '1;
    localparam logic [vec_w-1:0] vec_one  = 1;

    // Settle counter counts SETTLE-1 down to 0; keep at least one bit.
    localparam int cnt_w = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [cnt_w-1:0] cnt_load = (SETTLE > 0) ? cnt_w'(SETTLE - 1) : '0;
    localparam logic [cnt_w-1:0] cnt_one  = 1;

    localparam logic [15:0] err_max = 16'hFFFF;

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_settle = 2'd1;
    localparam logic [1:0] st_check  = 2'd2;
    localparam logic [1:0] st_done   = 2'd3;

    // With no settle time a freshly driven vector is checked on the next cycle.
    localparam logic [1:0] st_after_drive = (SETTLE == 0) ? st_check : st_settle;

    logic [1:0]         state_q, state_d;
    logic [vec_w-1:0]   vec_q, vec_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic [15:0]        err_q, err_d;
    logic [2*WIDTH:0]   fvec_q, fvec_d;
    logic               seen_q, seen_d;
    logic               pass_q, pass_d;

    logic [2*WIDTH:0]   cur_vec;
    logic [WIDTH:0]     expected;
    logic               mismatch;

    // Operand outputs are slices of the vector register, so they are glitch-free
    // and hold steady for the whole settle/check window of each vector.
`ifdef ADDER_BIST_CIN_EN
    always_comb begin
        A   = vec_q[2*WIDTH:WIDTH+1];
        B   = vec_q[WIDTH:1];
        Cin = vec_q[0];
    end
`else
    always_comb begin
        A   = vec_q[2*WIDTH-1:WIDTH];
        B   = vec_q[WIDTH-1:0];
        Cin = 1'b0;
    end
`endif

    // Reference sum at WIDTH+1 bits and comparison against the adder response.
    always_comb begin
        cur_vec  = {A, B, Cin};
        expected = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
        mismatch = (expected != {Cout, Sum});
    end

    // Sweep control and result bookkeeping.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        seen_d  = seen_q;
        pass_d  = pass_q;

        case (state_q)
            st_idle: begin
                if (start) begin
                    vec_d   = '0;
                    err_d   = '0;
                    fvec_d  = '0;
                    seen_d  = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = cnt_load;
                    state_d = st_after_drive;
                end
            end

            st_settle: begin
                if (cnt_q == '0) begin
                    state_d = st_check;
                end else begin
                    cnt_d = cnt_q - cnt_one;
                end
            end

            st_check: begin
                if (mismatch) begin
                    if (err_q != err_max) begin
                        err_d = err_q + 16'd1;
                    end
                    if (!seen_q) begin
                        fvec_d = cur_vec;
                        seen_d = 1'b1;
                    end
                end
                if (vec_q == vec_last) begin
                    // Verdict includes this final check, so it is valid in DONE.
                    pass_d  = (err_d == '0);
                    vec_d   = '0;
                    state_d = st_done;
                end else begin
                    vec_d   = vec_q + vec_one;
                    cnt_d   = cnt_load;
                    state_d = st_after_drive;
                end
            end

            st_done: begin
                state_d = st_idle;
            end

            default: begin
                state_d = st_idle;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= st_idle;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fvec_q  <= '0;
            seen_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            seen_q  <= seen_d;
            pass_q  <= pass_d;
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        busy      = (state_q == st_settle) || (state_q == st_check);
        done      = (state_q == st_done);
        pass      = pass_q;
        err_count = err_q;
        fail_vec  = fvec_q;
    end

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: drives a behavioural adder with selectable faults and
// checks the operand sweep and the final verdict against its own model.
module tb_adder_bist;

    localparam int W   = 4;
    localparam int S   = 1;
`ifdef ADDER_BIST_CIN_EN
    localparam int VW  = 2 * W + 1;
`else
    localparam int VW  = 2 * W;
`endif
    localparam int N   = 1 << VW;
    localparam int PER = S + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a, b, sum;
    logic           cin, cout;
    logic           busy, done, pass;
    logic [15:0]    err_count;
    logic [2*W:0]   fail_vec;

    int             fault = 0;
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [2*W:0]   exp_q[$];

    always #5 clk = ~clk;

    adder_bist #(.WIDTH(W), .SETTLE(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .Sum       (sum),
        .Cout      (cout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    // Adder model: 0 good, 1 Sum[0] stuck-0, 2 Cout stuck-0, 3 Cin ignored.
    function automatic logic [W:0] adder_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic ci, input int f);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, (f == 3) ? 1'b0 : ci};
        if (f == 1) r[0] = 1'b0;
        if (f == 2) r[W] = 1'b0;
        return r;
    endfunction

    always_comb {cout, sum} = adder_model(a, b, cin, fault);

    // {A,B,Cin} expected for sweep index v.
    function automatic logic [2*W:0] vec_of(input int v);
        logic [2*W:0] r;
`ifdef ADDER_BIST_CIN_EN
        r = v[2*W:0];
`else
        r = {v[2*W-1:0], 1'b0};
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " A/B/Cin"}, {23'd0, a, b, cin}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " pass"}, {31'd0, pass}, 32'd0);
        check({tag, " err_count"}, {16'd0, err_count}, 32'd0);
        check({tag, " fail_vec"}, {23'd0, fail_vec}, 32'd0);
    endtask

    // Entered at a negedge of an IDLE cycle; start is sampled on the next edge.
    // Returns at the negedge of the IDLE cycle after DONE (or mid-clock after
    // an abort via reset when the sweep reaches vector abort_at).
    task automatic sweep(input int f, input bit hold, input bit poke, input int abort_at);
        int           exp_err;
        logic [2*W:0] exp_fv;
        logic [2*W:0] cur;
        bit           seen;
        int           vi;
        fault   = f;
        exp_err = 0;
        exp_fv  = '0;
        seen    = 1'b0;
        vi      = 0;
        cur     = '0;
        for (int v = 0; v < N; v++) begin
            logic [2*W:0] t;
            t = vec_of(v);
            exp_q.push_back(t);
            if (adder_model(t[2*W:W+1], t[W:1], t[0], 0) != adder_model(t[2*W:W+1], t[W:1], t[0], f)) begin
                if (exp_err < 16'hFFFF) exp_err++;
                if (!seen) begin
                    exp_fv = t;
                    seen   = 1'b1;
                end
            end
        end
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int c = 1; c <= N * PER; c++) begin
            check("busy during sweep", {31'd0, busy}, 32'd1);
            check("done during sweep", {31'd0, done}, 32'd0);
            if ((c - 1) % PER == 0) begin
                vi = (c - 1) / PER;
                if (exp_q.size() == 0) begin
                    check("scoreboard empty", 32'd0, 32'd1);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            check("vector", {23'd0, a, b, cin}, {23'd0, cur});
            if (c == 1) begin
                check("err_count cleared", {16'd0, err_count}, 32'd0);
                check("pass cleared", {31'd0, pass}, 32'd0);
                check("fail_vec cleared", {23'd0, fail_vec}, 32'd0);
            end
            if (poke) begin
                if (c == 50 * PER + 1) start = 1'b1;
                else if (!hold) start = 1'b0;
            end
            if (abort_at >= 0 && vi == abort_at && (c - 1) % PER == 0) begin
                #2;
                rst   = 1'b1;
                start = 1'b1;
                #1;
                check_all_zero("async reset");
                exp_q.delete();
                return;
            end
            @(negedge clk);
        end
        check("done pulse", {31'd0, done}, 32'd1);
        check("busy at done", {31'd0, busy}, 32'd0);
        check("pass", {31'd0, pass}, {31'd0, (exp_err == 0)});
        check("err_count", {16'd0, err_count}, exp_err);
        check("fail_vec", {23'd0, fail_vec}, {23'd0, exp_fv});
        @(negedge clk);
        check("done single cycle", {31'd0, done}, 32'd0);
        check("busy in idle", {31'd0, busy}, 32'd0);
        check("idle operands", {23'd0, a, b, cin}, 32'd0);
        check("pass held", {31'd0, pass}, {31'd0, (exp_err == 0)});
        check("err_count held", {16'd0, err_count}, exp_err);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset with start");
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("idle busy", {31'd0, busy}, 32'd0);
        check("idle done", {31'd0, done}, 32'd0);

        sweep(0, 1'b0, 1'b0, -1);   // good adder
        sweep(1, 1'b0, 1'b1, -1);   // Sum[0] stuck, start poked mid-sweep
        sweep(2, 1'b0, 1'b0, -1);   // Cout stuck
        sweep(1, 1'b1, 1'b0, -1);   // start held: back-to-back sweeps
        sweep(0, 1'b1, 1'b0, -1);
        sweep(0, 1'b0, 1'b0, -1);
`ifdef ADDER_BIST_CIN_EN
        sweep(3, 1'b0, 1'b0, -1);   // adder ignores Cin
`endif

        // Reset at vector 100 of a failing sweep, then restart from vector 0.
        sweep(1, 1'b0, 1'b0, 100);
        @(negedge clk);
        check_all_zero("held in reset");
        rst   = 1'b0;
        start = 1'b0;
        fault = 0;
        @(negedge clk);
        check("no sweep without start", {31'd0, busy}, 32'd0);
        sweep(0, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
